// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC and issues one instruction-memory
// read at a time. Each fetched word is held for decode on a valid/ready port.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] pc_plus4_s;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    assign pc_plus4_s = pc_q + 32'd4;

    // Next-state logic; a redirect overrides every other event in the cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        misalign_d  = misalign_q;

        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end else begin
                misalign_d = misalign_q;
            end
            // A request already accepted by memory must have its response dropped.
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (imem_gnt) begin
                        discard_d = 1'b1;
                        state_d   = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        discard_d = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    state_d = ST_REQ;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_REQ;
                end
                ST_REQ: begin
                    if (imem_gnt) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = ST_REQ;
                        end else begin
                            inst_data_d = imem_rdata;
                            inst_pc_d   = pc_q;
                            pc_d        = pc_plus4_s;
                            state_d     = ST_HOLD;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (inst_ready) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            discard_q   <= 1'b0;
            inst_data_q <= 32'h0000_0000;
            inst_pc_q   <= 32'h0000_0000;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            discard_q   <= discard_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
            misalign_q  <= misalign_d;
        end
    end

    assign imem_req     = (state_q == ST_REQ);
    assign imem_addr    = pc_q;
    assign inst_valid   = (state_q == ST_HOLD);
    assign inst_data    = inst_data_q;
    assign inst_pc      = inst_pc_q;
    assign misalign_err = misalign_q;

endmodule
